inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Decoupled instruction-fetch stage directly upstream of the CPU decode/register-read path.
- Owns the fetch PC and issues sequential word requests to a variable-latency instruction memory.
- Buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts redirects (taken branch, jal/jalr) from execute and flushes wrong-path work.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- DEPTH, 2, instruction FIFO entries; legal range 2..8, power of two.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; state resets on any rising clk edge where rst==0.
- redirect_valid  in  1  single-cycle pulse from execute: fetch must restart at redirect_pc.
- redirect_pc  in  32  target PC (ALU result).
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  byte address of the word requested.
- imem_resp_valid  in  1  response data valid; in order; at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  FIFO head is valid.
- inst_ready  in  1  decode consumes the head this cycle.
- inst  out  32  head instruction.
- inst_pc  out  32  PC of head instruction.
- inst_pc_plus4  out  32  inst_pc+4, used as the link value for jal/jalr.
- misalign  out  1  misaligned redirect flag; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC.
  - FIFO empty; inst_valid=0.
  - imem_req_valid=0, outstanding=0, discard=0, misalign=0.
  - inst, inst_pc and inst_pc_plus4 drive 0 while empty.
- Reset mid-operation: any in-flight response arriving after reset is ignored, because outstanding=0.
- At most one outstanding memory request.
- Issue rule: imem_req_valid = !outstanding && (count + outstanding < DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - On acceptance (valid && ready): outstanding<=1 and fetch_pc<=fetch_pc+4, with 32-bit wrap from 32'hFFFF_FFFC to 0.
- Response rule: imem_resp_valid while outstanding clears outstanding.
  - If discard==0, push {data, pc_of_request} into the FIFO.
  - If discard==1, drop the response and clear discard.
- Space is reserved at issue time, so a push can never overflow the FIFO.
- Output: inst/inst_pc are the FIFO head with zero added latency.
  - Pop occurs when inst_valid && inst_ready.
  - A push into an empty FIFO is visible on the cycle after the response.
  - Simultaneous push and pop: count is unchanged.
- Redirect has priority over everything in its cycle:
  - The FIFO is flushed, and any same-cycle pop or push is discarded.
  - fetch_pc<=redirect_pc.
  - No request is issued that cycle.
  - If a request is outstanding and its response does not arrive in this same cycle, discard<=1.
  - The first request to the new target is issued on the following cycle, or once the discard response has drained.
  - Back-to-back redirects: the last one wins; discard remains a single flag because at most one request is outstanding.
- Memory backpressure: imem_req_addr must stay stable while imem_req_valid=1 and ready=0, unless redirect_valid is asserted, which withdraws the request.
- Latency: after a redirect with idle memory and 1-cycle memory latency, inst_valid rises 3 cycles after the redirect cycle.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign=1 and suppresses all fetch requests.
  - The FIFO stays flushed.
  - misalign clears only on a later aligned redirect or on reset.
- Not defined:
  - misalign is tied 0.
  - redirect_pc[1:0] is forced to 0 when loaded.

Decomposition:
- Package cpu_pkg:
  - XLEN=32, ILEN=32.
  - NOP_INST=32'h0000_0013.
  - typedef fetch_entry_t {inst[31:0], pc[31:0]}.
- One sub-module, inst_fifo:
  - Parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full.
  - Pointer-based, with wrap at DEPTH.

Test Plan:
1. Reset, imem 1-cycle latency, inst_ready=1 -> requests at addresses 0x0, 0x4, 0x8, 0xC; decode sees inst_pc 0x0, 0x4, 0x8 in order with matching data; inst_pc_plus4 = inst_pc+4.
2. inst_ready=0 held, DEPTH=2 -> exactly 2 requests accepted (0x0, 0x4), then imem_req_valid stays 0; releasing ready resumes fetching at 0x8.
3. Redirect to 0x100 while the request for 0x8 is outstanding (response 2 cycles later) -> the 0x8 data is dropped, the FIFO is empty, and the next issued addr is 0x100; the first inst_pc seen is 0x100.
4. imem_req_ready=0 for 3 cycles -> addr stays at 0x4 throughout, then fetching proceeds with no duplicate or skipped PC.
5. Redirect coinciding with a response and a pop -> none are committed; the next inst_pc is the redirect target 0x40.
6. With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> misalign=1 and no requests; a later redirect to 0x200 clears it and fetching restarts at 0x200. Without the macro, a redirect to 0x102 fetches from 0x100.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants for the fetch slice.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Memory-request tracking: idle, one live request, or one request whose data is stale.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    // Sequential next-word PC with natural 32-bit wrap.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory port and decode handshake.
interface inst_fetch_unit_if;
    import cpu_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;

    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_pc_plus4;
    logic            misalign;

    // Fetch unit side.
    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_ready,
        output imem_req_valid, imem_req_addr,
        output inst_valid, inst, inst_pc, inst_pc_plus4, misalign
    );

    // Execute / memory / decode side.
    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_ready,
        input  imem_req_valid, imem_req_addr,
        input  inst_valid, inst, inst_pc, inst_pc_plus4, misalign
    );

endinterface

// File: rtl/inst_fifo.sv
// Pointer-based synchronous FIFO of fetched {inst, pc} entries; flush empties it in one cycle.
module inst_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      cnt <= cnt + CW'(1);
            else if (do_pop && !do_push) cnt <= cnt - CW'(1);
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/inst_fetch_unit.sv
// Decoupled instruction fetch: owns the fetch PC, keeps one imem request in flight,
// buffers responses in inst_fifo and drops wrong-path data after a redirect.
// Optional build macro: FETCH_MISALIGN_CHECK_EN (flags misaligned redirects and halts fetch).
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_unit_if.master   bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e    state;
    fetch_state_e    state_n;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] redirect_tgt;
    logic            fetch_block;
    logic            outstanding;

    logic            req_valid_c;
    logic            req_fire;
    logic            resp_fire;
    logic            push;
    logic            pop;

    fetch_entry_t    push_data;
    fetch_entry_t    head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    // Sticky misalign flag: any redirect re-evaluates it from the target's low bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            misalign_q <= |bus.redirect_pc[1:0];
        end
    end

    assign redirect_tgt = bus.redirect_pc;
    assign fetch_block  = misalign_q;
    assign bus.misalign = misalign_q;
`else
    assign redirect_tgt = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign fetch_block  = 1'b0;
    assign bus.misalign = 1'b0;
`endif

    assign outstanding = (state != S_IDLE);

    // Request-tracking state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state plus issue/push/pop decisions; a redirect overrides everything this cycle.
    always_comb begin
        state_n     = state;
        req_valid_c = 1'b0;
        req_fire    = 1'b0;
        resp_fire   = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;

        req_valid_c = !outstanding
                      && ((fifo_count + CW'(outstanding)) < CW'(DEPTH))
                      && !bus.redirect_valid
                      && !fetch_block;
        req_fire    = req_valid_c && bus.imem_req_ready;
        resp_fire   = bus.imem_resp_valid && outstanding;
        pop         = !fifo_empty && bus.inst_ready && !bus.redirect_valid;

        case (state)
            S_IDLE: begin
                if (req_fire) state_n = S_BUSY;
            end
            S_BUSY: begin
                if (resp_fire) begin
                    state_n = S_IDLE;
                    push    = !bus.redirect_valid;
                end else if (bus.redirect_valid) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (resp_fire) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Fetch PC and the PC tagged onto the in-flight request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            if (bus.redirect_valid) begin
                fetch_pc <= redirect_tgt;
            end else if (req_fire) begin
                fetch_pc <= pc_next(fetch_pc);
            end
            if (req_fire) begin
                req_pc <= fetch_pc;
            end
        end
    end

    assign push_data.inst = bus.imem_resp_data;
    assign push_data.pc   = req_pc;

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .push_data (push_data),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = fetch_pc;

    // Decode view of the FIFO head; all-zero while empty.
    assign bus.inst_valid    = !fifo_empty;
    assign bus.inst          = fifo_empty ? '0 : head.inst;
    assign bus.inst_pc       = fifo_empty ? '0 : head.pc;
    assign bus.inst_pc_plus4 = fifo_empty ? '0 : pc_next(head.pc);

endmodule
